stream_fifo: RTL and testbench

- Single-clock, parametrised synchronous FIFO for staging operand and result words between the Paillier datapath stages.
- Supports any depth ≥ 2, including non-power-of-two depths.
- Selectable read mode: standard (1-cycle read latency) or first-word-fall-through (FWFT).
- Provides an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/stream_fifo_if.sv | 46 ++++
 rtl/fifo_ram.sv | 35 +++
 rtl/stream_fifo.sv | 155 +++++++++++++++
 tb/tb_stream_fifo.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and width helper for the stream FIFO slice.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam bit FIFO_STD  = 1'b0;
  localparam bit FIFO_FWFT = 1'b1;

  // Smallest number of bits able to index 'value' distinct items
  function automatic int fifo_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo_if
// Description : Write/read handshake, status and error bundle of stream_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) ();

  localparam int CW = fifo_clog2(DEPTH + 1);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  // Producer/consumer side
  modport master (
    output flush, wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  flush, wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : DEPTH x WIDTH storage, synchronous write, asynchronous read.
//               Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PW    = fifo_clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [PW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic [PW-1:0]    raddr,
  output      logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store one word per accepted write
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo
// Description : Single-clock FIFO with standard or FWFT read mode, occupancy
//               count, threshold flags, synchronous flush and sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter bit FWFT     = FIFO_STD,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input wire logic    clk,
  input wire logic    rst_n,
  stream_fifo_if.slave bus
);

  localparam int            CW       = fifo_clog2(DEPTH + 1);
  localparam int            PW       = fifo_clog2(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_accept, rd_accept;
  logic             is_full, is_empty;
  logic [WIDTH-1:0] ram_rdata;

  // Status is decoded from the registered count only
  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Accept logic, explicit pointer wrap, count and sticky error next-state
  always_comb begin
    wr_accept   = bus.wr_en && !is_full && !bus.flush;
    rd_accept   = bus.rd_en && !is_empty && !bus.flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // Clear first so a same-cycle set condition wins
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wr_en && is_full && !bus.flush) begin
      overflow_d = 1'b1;
    end
    if (bus.rd_en && is_empty && !bus.flush) begin
      underflow_d = 1'b1;
    end
  end

  // Pointer, count and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.count        = count_q;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  generate
    if (FWFT == FIFO_STD) begin : g_std
      logic [WIDTH-1:0] rd_data_q, rd_data_d;
      logic             rd_valid_q, rd_valid_d;

      // Capture the head word on an accepted read; pulse valid for one cycle
      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_accept;
        if (rd_accept) begin
          rd_data_d = ram_rdata;
        end
      end

      // Registered read data and valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end else begin : g_fwft
      // Head word is presented directly; rd_en acts as the pop acknowledge
      assign bus.rd_data  = is_empty ? '0 : ram_rdata;
      assign bus.rd_valid = !is_empty;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_fifo
// Description : Self-checking bench for stream_fifo in standard, FWFT and
//               threshold configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_fifo;
  import fifo_pkg::*;

  localparam int STD_DEPTH = 5;
  localparam int STD_AF    = STD_DEPTH - 1;
  localparam int STD_AE    = 1;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  stream_fifo_if #(.WIDTH(16), .DEPTH(STD_DEPTH)) if_std ();
  stream_fifo_if #(.WIDTH(16), .DEPTH(4))         if_fwft ();
  stream_fifo_if #(.WIDTH(16), .DEPTH(8))         if_thr ();

  stream_fifo #(.WIDTH(16), .DEPTH(STD_DEPTH), .FWFT(FIFO_STD)) u_std (
    .clk (clk), .rst_n (rst_n), .bus (if_std)
  );
  stream_fifo #(.WIDTH(16), .DEPTH(4), .FWFT(FIFO_FWFT)) u_fwft (
    .clk (clk), .rst_n (rst_n), .bus (if_fwft)
  );
  stream_fifo #(.WIDTH(16), .DEPTH(8), .FWFT(FIFO_STD), .AF_LEVEL(6), .AE_LEVEL(2)) u_thr (
    .clk (clk), .rst_n (rst_n), .bus (if_thr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        fl;
    logic        clr;
    logic [15:0] data;
    int          exp_count;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void add_vec(input logic wr, input logic rd, input logic fl, input logic clr,
                                  input logic [15:0] data, input int cnt, input logic f,
                                  input logic e, input logic o, input logic u);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.data = data;
    v.exp_count = cnt; v.exp_full = f; v.exp_empty = e; v.exp_ovf = o; v.exp_unf = u;
    vecs.push_back(v);
  endfunction

  function automatic void check_idle(input string tag, input int cnt, input logic e, input logic f,
                                     input logic ae, input logic af, input logic rv,
                                     input logic ov, input logic un, input logic [15:0] rd);
    check({tag, " count"}, cnt, 0);
    check({tag, " empty"}, e, 1);
    check({tag, " full"}, f, 0);
    check({tag, " almost_empty"}, ae, 1);
    check({tag, " almost_full"}, af, 0);
    check({tag, " rd_valid"}, rv, 0);
    check({tag, " overflow"}, ov, 0);
    check({tag, " underflow"}, un, 0);
    check({tag, " rd_data"}, rd, 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        v;
    int          model_cnt;
    logic        wr_acc;
    logic        rd_acc;
    logic [15:0] exp_data;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    {if_std.flush, if_std.wr_en, if_std.rd_en, if_std.clr_err} = '0;
    {if_fwft.flush, if_fwft.wr_en, if_fwft.rd_en, if_fwft.clr_err} = '0;
    {if_thr.flush, if_thr.wr_en, if_thr.rd_en, if_thr.clr_err} = '0;
    if_std.wr_data = '0; if_fwft.wr_data = '0; if_thr.wr_data = '0;

    // ---------------- Vector table for the DEPTH=5 standard FIFO
    for (int i = 1; i <= 5; i++) add_vec(1, 0, 0, 0, 16'(i), i, i == 5, 0, 0, 0);
    add_vec(1, 0, 0, 0, 16'h0006, 5, 1, 0, 1, 0);
    for (int i = 1; i <= 5; i++) add_vec(0, 1, 0, 0, 16'h0, 5 - i, 0, (5 - i) == 0, 1, 0);
    add_vec(0, 1, 0, 0, 16'h0, 0, 0, 1, 1, 1);
    add_vec(0, 0, 0, 1, 16'h0, 0, 0, 1, 0, 0);
    // wrap-around: one word primed, then 12 simultaneous write/read pairs
    add_vec(1, 0, 0, 0, 16'h0100, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) add_vec(1, 1, 0, 0, 16'(16'h0100 + i), 1, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 0);
    // full with both: read wins, write flags overflow
    for (int i = 1; i <= 5; i++) add_vec(1, 0, 0, 0, 16'(16'h0200 + i), i, i == 5, 0, 0, 0);
    add_vec(1, 1, 0, 0, 16'h02FF, 4, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) add_vec(0, 1, 0, 0, 16'h0, 4 - i, 0, (4 - i) == 0, 1, 0);
    // empty with both: write wins, read flags underflow
    add_vec(1, 1, 0, 0, 16'h0300, 1, 0, 0, 1, 1);
    add_vec(0, 0, 0, 1, 16'h0, 1, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 0);
    // clr_err and underflow in the same cycle: set wins
    add_vec(0, 1, 0, 1, 16'h0, 0, 0, 1, 0, 1);
    add_vec(0, 0, 0, 1, 16'h0, 0, 0, 1, 0, 0);
    // flush with 4 stored and a concurrent write
    for (int i = 1; i <= 4; i++) add_vec(1, 0, 0, 0, 16'(16'h0400 + i), i, 0, 0, 0, 0);
    add_vec(1, 0, 1, 0, 16'h04FF, 0, 0, 1, 0, 0);
    add_vec(1, 0, 0, 0, 16'h0500, 1, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 0);

    // ---------------- Reset state
    step();
    step();
    rst_n = 1'b1;
    step();
    check_idle("std reset", 32'(if_std.count), if_std.empty, if_std.full, if_std.almost_empty,
               if_std.almost_full, if_std.rd_valid, if_std.overflow, if_std.underflow, if_std.rd_data);
    check_idle("fwft reset", 32'(if_fwft.count), if_fwft.empty, if_fwft.full, if_fwft.almost_empty,
               if_fwft.almost_full, if_fwft.rd_valid, if_fwft.overflow, if_fwft.underflow, if_fwft.rd_data);
    check_idle("thr reset", 32'(if_thr.count), if_thr.empty, if_thr.full, if_thr.almost_empty,
               if_thr.almost_full, if_thr.rd_valid, if_thr.overflow, if_thr.underflow, if_thr.rd_data);

    // ---------------- Apply table with data scoreboard
    model_cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      v      = vecs[i];
      wr_acc = v.wr && (model_cnt < STD_DEPTH) && !v.fl;
      rd_acc = v.rd && (model_cnt > 0) && !v.fl;
      if (v.fl) sb.delete();
      if (wr_acc) sb.push_back(v.data);
      if_std.wr_en   = v.wr;
      if_std.rd_en   = v.rd;
      if_std.flush   = v.fl;
      if_std.clr_err = v.clr;
      if_std.wr_data = v.data;
      step();
      check($sformatf("std[%0d] count", i), 32'(if_std.count), v.exp_count);
      check($sformatf("std[%0d] full", i), if_std.full, v.exp_full);
      check($sformatf("std[%0d] empty", i), if_std.empty, v.exp_empty);
      check($sformatf("std[%0d] overflow", i), if_std.overflow, v.exp_ovf);
      check($sformatf("std[%0d] underflow", i), if_std.underflow, v.exp_unf);
      check($sformatf("std[%0d] almost_full", i), if_std.almost_full, v.exp_count >= STD_AF);
      check($sformatf("std[%0d] almost_empty", i), if_std.almost_empty, v.exp_count <= STD_AE);
      check($sformatf("std[%0d] rd_valid", i), if_std.rd_valid, rd_acc);
      if (if_std.rd_valid) begin
        if (sb.size() == 0) begin
          tests = tests + 1;
          fails = fails + 1;
          $display("FAIL std[%0d] rd_data: got 0x%0h, expected no read", i, if_std.rd_data);
        end else begin
          exp_data = sb.pop_front();
          check($sformatf("std[%0d] rd_data", i), if_std.rd_data, exp_data);
        end
      end
      model_cnt = v.exp_count;
    end
    {if_std.flush, if_std.wr_en, if_std.rd_en, if_std.clr_err} = '0;
    check("std scoreboard drained", sb.size(), 0);

    // ---------------- Thresholds: DEPTH=8, AF=6, AE=2
    if_thr.wr_en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      if_thr.wr_data = 16'(16'h0020 + c);
      step();
      check($sformatf("thr fill %0d count", c), 32'(if_thr.count), c);
      check($sformatf("thr fill %0d almost_empty", c), if_thr.almost_empty, c <= 2);
      check($sformatf("thr fill %0d almost_full", c), if_thr.almost_full, c >= 6);
    end
    if_thr.wr_en = 1'b0;
    if_thr.rd_en = 1'b1;
    for (int c = 7; c >= 0; c--) begin
      step();
      check($sformatf("thr drain %0d count", c), 32'(if_thr.count), c);
      check($sformatf("thr drain %0d almost_empty", c), if_thr.almost_empty, c <= 2);
      check($sformatf("thr drain %0d almost_full", c), if_thr.almost_full, c >= 6);
      check($sformatf("thr drain %0d rd_valid", c), if_thr.rd_valid, 1);
      check($sformatf("thr drain %0d rd_data", c), if_thr.rd_data, 16'h0020 + 16'(8 - c));
    end
    if_thr.rd_en = 1'b0;

    // ---------------- FWFT: word appears the cycle after the write
    if_fwft.wr_en   = 1'b1;
    if_fwft.wr_data = 16'hABCD;
    step();
    if_fwft.wr_en = 1'b0;
    check("fwft first rd_valid", if_fwft.rd_valid, 1);
    check("fwft first rd_data", if_fwft.rd_data, 16'hABCD);
    check("fwft first count", 32'(if_fwft.count), 1);
    if_fwft.rd_en = 1'b1;
    step();
    if_fwft.rd_en = 1'b0;
    check("fwft ack empty", if_fwft.empty, 1);
    check("fwft ack rd_data", if_fwft.rd_data, 0);
    check("fwft ack rd_valid", if_fwft.rd_valid, 0);
    if_fwft.wr_en   = 1'b1;
    if_fwft.wr_data = 16'h00A1;
    step();
    if_fwft.wr_data = 16'h00A2;
    step();
    if_fwft.wr_en = 1'b0;
    check("fwft pair head", if_fwft.rd_data, 16'h00A1);
    check("fwft pair count", 32'(if_fwft.count), 2);
    if_fwft.rd_en = 1'b1;
    step();
    check("fwft pair second", if_fwft.rd_data, 16'h00A2);
    check("fwft pair second valid", if_fwft.rd_valid, 1);
    step();
    check("fwft pair drained", if_fwft.empty, 1);
    // one more pop on empty raises underflow ahead of the reset test
    step();
    if_fwft.rd_en = 1'b0;
    check("fwft underflow", if_fwft.underflow, 1);

    // ---------------- Asynchronous reset mid-stream
    if_std.wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_std.wr_data = 16'(16'h0600 + i);
      step();
    end
    if_std.wr_en = 1'b0;
    if_std.rd_en = 1'b1;
    step();
    if_std.rd_en = 1'b0;
    check("pre-reset std rd_data", if_std.rd_data, 16'h0600);
    check("pre-reset std count", 32'(if_std.count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("std async reset", 32'(if_std.count), if_std.empty, if_std.full, if_std.almost_empty,
               if_std.almost_full, if_std.rd_valid, if_std.overflow, if_std.underflow, if_std.rd_data);
    check_idle("fwft async reset", 32'(if_fwft.count), if_fwft.empty, if_fwft.full, if_fwft.almost_empty,
               if_fwft.almost_full, if_fwft.rd_valid, if_fwft.overflow, if_fwft.underflow, if_fwft.rd_data);
    #2;
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
